// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared coordinate width, phase type, axis helpers and standard mode timings
package video_timing_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_e;

    function automatic int axis_total(input int a, input int f, input int s, input int b);
        return a + f + s + b;
    endfunction

    function automatic bit axis_legal(input int a, input int f, input int s, input int b);
        return a >= 1 && f >= 1 && s >= 1 && b >= 1 && axis_total(a, f, s, b) < (1 << COORD_W);
    endfunction

    function automatic phase_e phase_of(input logic [COORD_W-1:0] c, input int a, input int f, input int s);
        return c < COORD_W'(a) ? PH_ACTIVE :
               c < COORD_W'(a + f) ? PH_FP :
               c < COORD_W'(a + f + s) ? PH_SYNC : PH_BP;
    endfunction

    localparam int P720_H_ACTIVE = 1280;
    localparam int P720_H_FP     = 110;
    localparam int P720_H_SYNC   = 40;
    localparam int P720_H_BP     = 220;
    localparam int P720_V_ACTIVE = 720;
    localparam int P720_V_FP     = 5;
    localparam int P720_V_SYNC   = 5;
    localparam int P720_V_BP     = 20;
    localparam bit P720_HS_POL   = 1'b1;
    localparam bit P720_VS_POL   = 1'b1;

    localparam int P480_H_ACTIVE = 640;
    localparam int P480_H_FP     = 16;
    localparam int P480_H_SYNC   = 96;
    localparam int P480_H_BP     = 48;
    localparam int P480_V_ACTIVE = 480;
    localparam int P480_V_FP     = 10;
    localparam int P480_V_SYNC   = 2;
    localparam int P480_V_BP     = 33;
    localparam bit P480_HS_POL   = 1'b0;
    localparam bit P480_VS_POL   = 1'b0;

endpackage

// File: rtl/timing_axis_cnt.sv
// timing_axis_cnt: wrapping counter for one raster axis with ACTIVE/FP/SYNC/BP phase decode
module timing_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = P720_H_ACTIVE,
    parameter int FP     = P720_H_FP,
    parameter int SYNC   = P720_H_SYNC,
    parameter int BP     = P720_H_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    output logic [COORD_W-1:0] cnt,
    output logic [1:0]         phase,
    output logic               wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    if (!axis_legal(ACTIVE, FP, SYNC, BP)) begin : g_illegal
        $error("timing_axis_cnt: widths must be >= 1 and total < 2**COORD_W");
    end

    logic [COORD_W-1:0] r_cnt;

    assign wrap  = r_cnt == COORD_W'(TOTAL - 1);
    assign cnt   = r_cnt;
    assign phase = phase_of(r_cnt, ACTIVE, FP, SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (step)
            r_cnt <= wrap ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel-clock raster generator producing registered hs/vs/de, coordinates and frame_start
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = P720_H_ACTIVE,
    parameter int H_FP     = P720_H_FP,
    parameter int H_SYNC   = P720_H_SYNC,
    parameter int H_BP     = P720_H_BP,
    parameter int V_ACTIVE = P720_V_ACTIVE,
    parameter int V_FP     = P720_V_FP,
    parameter int V_SYNC   = P720_V_SYNC,
    parameter int V_BP     = P720_V_BP,
    parameter bit HS_POL   = P720_HS_POL,
    parameter bit VS_POL   = P720_VS_POL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start
);

    logic [COORD_W-1:0] w_h_cnt, w_v_cnt;
    logic [1:0]         w_h_phase, w_v_phase;
    logic               w_h_wrap, w_v_wrap_unused, w_de;
    logic               r_hs, r_vs, r_de, r_fs;
    logic [COORD_W-1:0] r_x, r_y;

    timing_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk(clk), .rst_n(rst_n), .step(en),
        .cnt(w_h_cnt), .phase(w_h_phase), .wrap(w_h_wrap)
    );

    // vertical axis advances once per completed line, so its phase only moves at h_cnt=0
    timing_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk(clk), .rst_n(rst_n), .step(en && w_h_wrap),
        .cnt(w_v_cnt), .phase(w_v_phase), .wrap(w_v_wrap_unused)
    );

    assign w_de = w_h_phase == PH_ACTIVE && w_v_phase == PH_ACTIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
            r_de <= 1'b0;
            r_x  <= '0;
            r_y  <= '0;
            r_fs <= 1'b0;
        end else begin
            r_fs <= en && w_h_cnt == '0 && w_v_cnt == '0;
            if (en) begin
                r_hs <= w_h_phase == PH_SYNC ? HS_POL : ~HS_POL;
                r_vs <= w_v_phase == PH_SYNC ? VS_POL : ~VS_POL;
                r_de <= w_de;
                r_x  <= w_de ? w_h_cnt : '0;
                r_y  <= w_de ? w_v_cnt : '0;
            end
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: table vectors plus a queued raster model checking both sync polarities
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 2, HB = 2, HT = 14;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1, VT = 7;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic hs, vs, de, fs, hs_n, vs_n, de_n, fs_n;
    logic [11:0] x, y, x_n, y_n;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hs(hs), .vs(vs), .de(de),
        .x(x), .y(y), .frame_start(fs)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .en(en), .hs(hs_n), .vs(vs_n), .de(de_n),
        .x(x_n), .y(y_n), .frame_start(fs_n)
    );

    typedef struct packed {
        logic        en;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        fs;
    } vec_t;

    vec_t tbl[24];
    vec_t q[$];
    vec_t last;
    int   mh, mv;
    int   n_chk = 0, n_fail = 0;

    function automatic vec_t mk(input logic e, input logic d, input int xx, input int yy,
                                input logic h, input logic v, input logic f);
        vec_t r;
        r.en = e; r.de = d; r.x = 12'(xx); r.y = 12'(yy); r.hs = h; r.vs = v; r.fs = f;
        return r;
    endfunction

    // independent decode of the raster position straight from the porch/sync ranges
    function automatic vec_t model(input int h, input int v);
        logic d;
        d = h < HA && v < VA;
        return mk(1'b1, d, d ? h : 0, d ? v : 0,
                  h >= HA + HF && h < HA + HF + HSW,
                  v >= VA + VF && v < VA + VF + VSW,
                  h == 0 && v == 0);
    endfunction

    function automatic vec_t got(input logic e);
        return mk(e, de, int'(x), int'(y), hs, vs, fs);
    endfunction

    function automatic vec_t got_n(input logic e);
        return mk(e, de_n, int'(x_n), int'(y_n), ~hs_n, ~vs_n, fs_n);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("reset_pos", 32'(got(1'b0)), 32'(mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0)));
        check("reset_neg", 32'({hs_n, vs_n, de_n, x_n, y_n, fs_n}), 32'({1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        mh = 0;
        mv = 0;
        last = mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run(input int n, input bit rnd);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (en) begin
                e = model(mh, mv);
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else
                    mh++;
            end else begin
                e = last;
                e.en = 1'b0;
                e.fs = 1'b0;
            end
            last = e;
            q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            e = q.pop_front();
            check("sb_pos", 32'(got(e.en)), 32'(e));
            check("sb_neg", 32'(got_n(e.en)), 32'(e));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int fs_t[$];
        int vs_rise, hs_rise, vs_cnt, de_cnt, fs_cnt;
        logic pvs, phs;

        tbl[0] = mk(1, 1, 0, 0, 0, 0, 1);
        for (int i = 1; i < 8; i++) tbl[i] = mk(1, 1, i, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 1, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 1, 0, 1, 0, 0, 0);
        tbl[15] = mk(1, 1, 1, 1, 0, 0, 0);
        tbl[16] = mk(1, 1, 2, 1, 0, 0, 0);
        tbl[17] = mk(1, 1, 3, 1, 0, 0, 0);
        for (int i = 18; i < 23; i++) tbl[i] = mk(0, 1, 3, 1, 0, 0, 0);
        tbl[23] = mk(1, 1, 4, 1, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 24; i++) begin
            en = tbl[i].en;
            q.push_back(tbl[i]);
            @(posedge clk);
            @(negedge clk);
            e = q.pop_front();
            check($sformatf("vec%0d", i), 32'(got(e.en)), 32'(e));
        end

        do_reset();
        run(400, 1'b1);

        do_reset();
        en = 1'b1;
        vs_rise = -1; hs_rise = -1; vs_cnt = 0; de_cnt = 0;
        pvs = 1'b0; phs = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (fs) fs_t.push_back(c);
            if (c <= 98) begin
                vs_cnt += int'(vs);
                de_cnt += int'(de);
            end
            if (vs && !pvs && vs_rise < 0) begin
                vs_rise = c;
                check("vs_rise_hs_low", 32'(hs), 32'(0));
            end
            if (hs && !phs && hs_rise < 0) hs_rise = c;
            pvs = vs;
            phs = hs;
        end
        check("fs_count", 32'(fs_t.size()), 32'(3));
        if (fs_t.size() >= 3) begin
            check("fs_first", 32'(fs_t[0]), 32'(1));
            check("fs_period1", 32'(fs_t[1] - fs_t[0]), 32'(98));
            check("fs_period2", 32'(fs_t[2] - fs_t[1]), 32'(98));
        end
        check("vs_width", 32'(vs_cnt), 32'(14));
        check("de_per_frame", 32'(de_cnt), 32'(32));
        check("vs_rise_cycle", 32'(vs_rise), 32'(71));
        check("hs_rise_cycle", 32'(hs_rise), 32'(11));

        do_reset();
        run(79, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        fs_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) check("post_reset_first", 32'(got(1'b1)), 32'(mk(1, 1, 0, 0, 0, 0, 1)));
            fs_cnt += int'(fs);
        end
        check("post_reset_fs_pulses", 32'(fs_cnt), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
